// File: rtl/binary_to_grey.sv
// Binary-to-Gray converter: combinational path, registered capture stage and Gray-coded counter.
// Optional combinational Gray-to-binary decoder enabled by defining BINARY_TO_GREY_DECODE_EN.
module binary_to_grey #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] binary_in,
    output logic [WIDTH-1:0] gray_out,
    input  logic             in_valid,
    output logic [WIDTH-1:0] gray_q,
    output logic             out_valid,
    input  logic             cnt_en,
    input  logic             cnt_clr,
`ifdef BINARY_TO_GREY_DECODE_EN
    output logic [WIDTH-1:0] cnt_gray,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] binary_out
`else
    output logic [WIDTH-1:0] cnt_gray
`endif
);

    logic [WIDTH-1:0] bcnt;
    logic [WIDTH-1:0] bcnt_next;
    logic [WIDTH-1:0] cnt_gray_next;

    assign gray_out[WIDTH-1]      = binary_in[WIDTH-1];
    assign cnt_gray_next[WIDTH-1] = bcnt_next[WIDTH-1];

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_gray_bit
            assign gray_out[gi]      = binary_in[gi+1] ^ binary_in[gi];
            assign cnt_gray_next[gi] = bcnt_next[gi+1] ^ bcnt_next[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                gray_q <= gray_out;
            end
            out_valid <= in_valid;
        end
    end

    // Clear has priority over enable; the add wraps naturally modulo 2^WIDTH.
    always_comb begin
        bcnt_next = bcnt;
        if (cnt_clr) begin
            bcnt_next = '0;
        end else if (cnt_en) begin
            bcnt_next = bcnt + WIDTH'(1);
        end
    end

    // Gray value is registered from the next binary count so cnt_gray is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt     <= '0;
            cnt_gray <= '0;
        end else begin
            bcnt     <= bcnt_next;
            cnt_gray <= cnt_gray_next;
        end
    end

`ifdef BINARY_TO_GREY_DECODE_EN
    always_comb begin
        binary_out = '0;
        binary_out[WIDTH-1] = gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            binary_out[i] = binary_out[i+1] ^ gray_in[i];
        end
    end
`endif

endmodule

// File: tb/tb_binary_to_grey.sv
// Directed self-checking bench for binary_to_grey (WIDTH=4); decoder checks run when
// BINARY_TO_GREY_DECODE_EN is defined.
module tb_binary_to_grey;

    logic       clk;
    logic       rst_n;
    logic [3:0] binary_in;
    logic [3:0] gray_out;
    logic       in_valid;
    logic [3:0] gray_q;
    logic       out_valid;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] cnt_gray;
`ifdef BINARY_TO_GREY_DECODE_EN
    logic [3:0] gray_in;
    logic [3:0] binary_out;
`endif

    int tests = 0;
    int fails = 0;

    // Hand-computed Gray codes of 0..15 and the binary values decoded from Gray codes 0..15.
    logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                  4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
`ifdef BINARY_TO_GREY_DECODE_EN
    logic [3:0] inv_tab  [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0111, 4'b0110, 4'b0100, 4'b0101,
                                  4'b1111, 4'b1110, 4'b1100, 4'b1101, 4'b1000, 4'b1001, 4'b1011, 4'b1010};
`endif

    binary_to_grey #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .binary_in (binary_in),
        .gray_out  (gray_out),
        .in_valid  (in_valid),
        .gray_q    (gray_q),
        .out_valid (out_valid),
        .cnt_en    (cnt_en),
        .cnt_clr   (cnt_clr),
`ifdef BINARY_TO_GREY_DECODE_EN
        .cnt_gray  (cnt_gray),
        .gray_in   (gray_in),
        .binary_out(binary_out)
`else
        .cnt_gray  (cnt_gray)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for a rising edge, then sample 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] prev;
        rst_n     = 1'b0;
        binary_in = 4'b0000;
        in_valid  = 1'b0;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b0;
`ifdef BINARY_TO_GREY_DECODE_EN
        gray_in   = 4'b0000;
`endif
        #1;
        check("reset_gray_q", 32'(gray_q), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_cnt_gray", 32'(cnt_gray), 32'h0);

        // Combinational sweep, independent of clock and reset.
        for (int x = 0; x < 16; x++) begin
            binary_in = 4'(x);
            #1;
            check($sformatf("gray_out_%0d", x), 32'(gray_out), 32'(gray_tab[x]));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Single capture of 0110, then idle.
        @(negedge clk);
        binary_in = 4'b0110;
        in_valid  = 1'b1;
        tick();
        check("cap_gray_q", 32'(gray_q), 32'h5);
        check("cap_out_valid", 32'(out_valid), 32'h1);
        in_valid  = 1'b0;
        binary_in = 4'b1111;
        tick();
        check("hold_out_valid", 32'(out_valid), 32'h0);
        check("hold_gray_q", 32'(gray_q), 32'h5);

        // Back-to-back captures: 1010 -> 1111, 0011 -> 0010.
        @(negedge clk);
        binary_in = 4'b1010;
        in_valid  = 1'b1;
        tick();
        check("b2b0_gray_q", 32'(gray_q), 32'hF);
        check("b2b0_out_valid", 32'(out_valid), 32'h1);
        binary_in = 4'b0011;
        tick();
        check("b2b1_gray_q", 32'(gray_q), 32'h2);
        check("b2b1_out_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;

        // Counter sweep of 16 enabled edges from 0, including wrap.
        check("cnt_start", 32'(cnt_gray), 32'h0);
        @(negedge clk);
        cnt_en = 1'b1;
        prev   = cnt_gray;
        for (int k = 0; k < 16; k++) begin
            tick();
            check($sformatf("cnt_step_%0d", k), 32'(cnt_gray), 32'(gray_tab[(k + 1) % 16]));
            check($sformatf("cnt_onebit_%0d", k), 32'($countones(prev ^ cnt_gray)), 32'h1);
            prev = cnt_gray;
        end
        // Advance to binary 4 (Gray 0110), then hold with enable low.
        for (int k = 0; k < 4; k++) tick();
        check("cnt_at_0110", 32'(cnt_gray), 32'h6);
        cnt_en = 1'b0;
        tick();
        check("cnt_hold", 32'(cnt_gray), 32'h6);
        // Clear beats enable.
        cnt_en  = 1'b1;
        cnt_clr = 1'b1;
        tick();
        check("cnt_clr_priority", 32'(cnt_gray), 32'h0);
        cnt_clr = 1'b0;

        // Build gray_q=1111 and cnt_gray=0101, then reset asynchronously mid-cycle.
        binary_in = 4'b1010;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("pre_rst_gray_q", 32'(gray_q), 32'hF);
        check("pre_rst_cnt_gray", 32'(cnt_gray), 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gray_q", 32'(gray_q), 32'h0);
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_cnt_gray", 32'(cnt_gray), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_cnt", 32'(cnt_gray), 32'h0);
        tick();
        check("restart_cnt_1", 32'(cnt_gray), 32'h1);
        tick();
        check("restart_cnt_2", 32'(cnt_gray), 32'h3);
        cnt_en = 1'b0;

`ifdef BINARY_TO_GREY_DECODE_EN
        for (int g = 0; g < 16; g++) begin
            gray_in = 4'(g);
            #1;
            check($sformatf("decode_%0d", g), 32'(binary_out), 32'(inv_tab[g]));
        end
        for (int x = 0; x < 16; x++) begin
            binary_in = 4'(x);
            #1;
            gray_in = gray_out;
            #1;
            check($sformatf("roundtrip_%0d", x), 32'(binary_out), 32'(x));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
